calc_operand_sequencer: RTL and testbench

Front-end input stage of the 8-bit calculator; sits directly upstream of the ALU and drives its in1, in2 and opcode inputs. It debounces the Enter and Clear buttons and runs a four-state entry FSM so the user can load operand A, then operand B, then the opcode from the slide switches. When all three are loaded, it flags result_valid so the display stage shows the ALU output.

---
 rtl/calc_operand_sequencer.sv | 162 ++++++++++++++++
 tb/tb_calc_operand_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_sequencer.sv
// Calculator front end: debounced Enter/Clear buttons drive a four-state entry FSM that loads the ALU operands and opcode.
// Optional feature: define CALC_CHAIN_EN so that Enter in S_RESULT loads the ALU result into operand A.

module calc_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      // p0/p1: metastability guard for the asynchronous button
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Rising-edge pulse only; releases are silent
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end
endmodule

module calc_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic [7:0] alu_result,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [2:0] opcode,
  output logic [1:0] state,
  output logic       result_valid,
  output logic       op_error
);
  typedef enum logic [1:0] {
    S_A      = 2'b00,
    S_B      = 2'b01,
    S_OP     = 2'b10,
    S_RESULT = 2'b11
  } state_t;

  state_t     st;
  logic [7:0] sw_p0;
  logic [7:0] sw_p1;
  logic       enter_pulse;
  logic       clear_pulse;

  function automatic logic opcode_ok(input logic [7:0] v);
    return (v[7:3] == 5'd0) && (v[2:0] <= 3'b100);
  endfunction

`ifndef CALC_CHAIN_EN
  logic unused_alu;
  assign unused_alu = ^alu_result;
`endif

  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_enter),
    .pulse(enter_pulse)
  );

  calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_clear),
    .pulse(clear_pulse)
  );

  assign state = st;

  // p0/p1: switch synchronizer, captured value is sw_p1
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  // Entry FSM; Clear outranks a coincident Enter
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= S_A;
      in1          <= '0;
      in2          <= '0;
      opcode       <= '0;
      result_valid <= 1'b0;
      op_error     <= 1'b0;
    end else if (clear_pulse) begin
      st           <= S_A;
      in1          <= '0;
      in2          <= '0;
      opcode       <= '0;
      result_valid <= 1'b0;
      op_error     <= 1'b0;
    end else if (enter_pulse) begin
      case (st)
        S_A: begin
          in1 <= sw_p1;
          st  <= S_B;
        end
        S_B: begin
          in2 <= sw_p1;
          st  <= S_OP;
        end
        S_OP: begin
          if (opcode_ok(sw_p1)) begin
            opcode       <= sw_p1[2:0];
            op_error     <= 1'b0;
            st           <= S_RESULT;
            result_valid <= 1'b1;
          end else begin
            op_error <= 1'b1;
          end
        end
        default: begin
`ifdef CALC_CHAIN_EN
          in1 <= alu_result;
          st  <= S_B;
`else
          st  <= S_A;
`endif
          result_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer: directed test-plan steps followed by randomized button actions against a spec-level model.
module tb_calc_operand_sequencer;
  localparam int D = 4;
  localparam int PRESS_LAT = D + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [7:0] alu_result;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [2:0] opcode;
  logic [1:0] state;
  logic       result_valid;
  logic       op_error;

  int checks = 0;
  int errors = 0;

  // Reference model: user-visible register contents after each accepted press
  int         m_state;
  logic [7:0] m_in1;
  logic [7:0] m_in2;
  logic [2:0] m_opc;
  logic       m_err;

  calc_operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .alu_result  (alu_result),
    .in1         (in1),
    .in2         (in2),
    .opcode      (opcode),
    .state       (state),
    .result_valid(result_valid),
    .op_error    (op_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in1"}, in1, m_in1);
    check({tag, ".in2"}, in2, m_in2);
    check({tag, ".opcode"}, opcode, m_opc);
    check({tag, ".state"}, state, m_state);
    check({tag, ".result_valid"}, result_valid, (m_state == 3) ? 1 : 0);
    check({tag, ".op_error"}, op_error, m_err);
  endtask

  task automatic model_clear();
    m_state = 0;
    m_in1   = 0;
    m_in2   = 0;
    m_opc   = 0;
    m_err   = 0;
  endtask

  task automatic model_enter(input logic [7:0] v, input logic [7:0] alu);
    if (m_state == 0) begin
      m_in1   = v;
      m_state = 1;
    end else if (m_state == 1) begin
      m_in2   = v;
      m_state = 2;
    end else if (m_state == 2) begin
      if (v <= 8'd4) begin
        m_opc   = v[2:0];
        m_err   = 0;
        m_state = 3;
      end else begin
        m_err = 1;
      end
    end else begin
`ifdef CALC_CHAIN_EN
      m_in1   = alu;
      m_state = 1;
`else
      m_state = 0;
`endif
    end
  endtask

  // One button action: optional bounce, stable press, exact-latency checks, release
  task automatic press(input string tag, input logic e, input logic c, input logic bounce,
                       input logic [7:0] swv, input logic [7:0] alu);
    sw         = swv;
    alu_result = alu;
    if (bounce) begin
      for (int k = 0; k < 2; k++) begin
        btn_enter = 1'b1;
        tick();
        tick();
        btn_enter = 1'b0;
        tick();
        tick();
      end
      check_all({tag, ".bounce"});
    end
    btn_enter = e;
    btn_clear = c;
    repeat (PRESS_LAT) tick();
    check_all({tag, ".pre"});
    tick();
    if (c) model_clear();
    else if (e) model_enter(swv, alu);
    check_all({tag, ".post"});
    repeat (6) tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (D + 6) tick();
    check_all({tag, ".rel"});
  endtask

  initial begin
    reset      = 1'b1;
    sw         = 8'h00;
    btn_enter  = 1'b0;
    btn_clear  = 1'b0;
    alu_result = 8'h00;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_all("reset");

    press("enA", 1, 0, 0, 8'h3C, 8'h00);
    press("enB", 1, 0, 0, 8'h05, 8'h00);
    press("enOP", 1, 0, 0, 8'h03, 8'h00);
    check("result_valid_after3", result_valid, 1);

    press("bounce", 1, 0, 1, 8'h11, 8'h22);

    press("clr1", 0, 1, 0, 8'hAA, 8'h00);
    press("opA", 1, 0, 0, 8'h12, 8'h00);
    press("opB", 1, 0, 0, 8'h34, 8'h00);
    press("badop07", 1, 0, 0, 8'h07, 8'h00);
    press("badop12", 1, 0, 0, 8'h12, 8'h00);
    press("goodop04", 1, 0, 0, 8'h04, 8'h00);

    press("clr2", 0, 1, 0, 8'h00, 8'h00);
    press("sbA", 1, 0, 0, 8'h5A, 8'h00);
    press("both", 1, 1, 0, 8'h66, 8'h00);

    press("rsA", 1, 0, 0, 8'hFF, 8'h00);
    press("rsB", 1, 0, 0, 8'h01, 8'h00);
    press("rsOP", 1, 0, 0, 8'h02, 8'h00);
    reset = 1'b1;
    tick();
    model_clear();
    check_all("midreset");
    reset = 1'b0;
    tick();

    press("chA", 1, 0, 0, 8'h10, 8'h00);
    press("chB", 1, 0, 0, 8'h20, 8'h00);
    press("chOP", 1, 0, 0, 8'h01, 8'h00);
    press("chain", 1, 0, 0, 8'h99, 8'h41);

    // Button held through reset is seen as a fresh press
    sw        = 8'h5A;
    btn_enter = 1'b1;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    repeat (PRESS_LAT) tick();
    check_all("held.pre");
    tick();
    model_enter(8'h5A, alu_result);
    check_all("held.post");
    btn_enter = 1'b0;
    repeat (D + 6) tick();
    check_all("held.rel");

    for (int i = 0; i < 24; i++) begin
      int         r;
      logic [7:0] v;
      logic [7:0] a;
      r = $urandom_range(0, 9);
      v = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      a = 8'($urandom_range(0, 255));
      if (r == 0) press("rnd.clr", 0, 1, 0, v, a);
      else if (r == 1) press("rnd.both", 1, 1, 0, v, a);
      else if (r == 2) press("rnd.bounce", 1, 0, 1, v, a);
      else press("rnd.enter", 1, 0, 0, v, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
